// File: rtl/shift_sfr_pkg.sv
// Shared encodings for the shift SFR command sequencer.
// State encoding and direction constants used by the FSM and its counter.
// No logic lives here.
package shift_sfr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    RESP  = ST_RESP
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_count.sv
// Loadable down counter holding the remaining number of 1-bit shifts.
// Load clamps the amount to SIZE; counter saturates at zero.
// Zero flag is a pure decode of the registered count.
module shift_count
  import shift_sfr_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [AMT_W-1:0] i_amt,
  output logic [AMT_W-1:0] o_cnt,
  output logic             o_zero
);

  localparam logic [AMT_W-1:0] CNT_MAX = AMT_W'(SIZE);

  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_load_val;

  // Amounts of SIZE or more all empty the register, so cap them at SIZE.
  always_comb begin
    w_load_val = (i_amt >= CNT_MAX) ? CNT_MAX : i_amt;
  end

  // Count register: load wins over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_sfr_sequencer.sv
// Command front-end for the left/right shift SFR: one command in, one result out.
// Latency: response (ld?1:0)+min(amt,SIZE) edges after acceptance; one idle bubble between commands.
// Backpressure: cmd_ready only in IDLE; RESP holds rsp_valid/rsp_data until rsp_ready.
module shift_sfr_sequencer
  import shift_sfr_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [SIZE-1:0]  cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SIZE-1:0]  rsp_data,
  output logic             sfr_ld,
  output logic             sfr_left,
  output logic             sfr_right,
  output logic [SIZE-1:0]  sfr_d,
  input  logic [SIZE-1:0]  sfr_q
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic [SIZE-1:0]  r_data;
  logic             w_accept;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_cnt_last;
  logic [AMT_W-1:0] w_cnt;

  assign w_accept   = cmd_valid && (r_state == IDLE);
  assign w_cnt_dec  = (r_state == SHIFT);
  assign w_cnt_last = (w_cnt == AMT_W'(1));

  shift_count #(
    .SIZE  (SIZE),
    .AMT_W (AMT_W)
  ) u_shift_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_dec  (w_cnt_dec),
    .i_amt  (cmd_amt),
    .o_cnt  (w_cnt),
    .o_zero (w_cnt_zero)
  );

  // State register; reset aborts any command in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture direction and load data on acceptance; held stable while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= DIR_LEFT;
      r_data <= '0;
    end else if (w_accept) begin
      r_dir  <= cmd_dir;
      r_data <= cmd_data;
    end
  end

  // Next state; a non-zero amount stays non-zero after clamping, so cmd_amt decides directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_ld)              w_state_nxt = LOAD;
          else if (cmd_amt != '0)  w_state_nxt = SHIFT;
          else                     w_state_nxt = RESP;
        end
      end
      LOAD:    w_state_nxt = w_cnt_zero ? RESP : SHIFT;
      SHIFT:   w_state_nxt = w_cnt_last ? RESP : SHIFT;
      RESP:    w_state_nxt = rsp_ready ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state only; at most one SFR control is active.
  always_comb begin
    cmd_ready = (r_state == IDLE);
    sfr_ld    = (r_state == LOAD);
    sfr_d     = (r_state == LOAD) ? r_data : '0;
    sfr_left  = (r_state == SHIFT) && (r_dir == DIR_LEFT);
    sfr_right = (r_state == SHIFT) && (r_dir == DIR_RIGHT);
    rsp_valid = (r_state == RESP);
    rsp_data  = (r_state == RESP) ? sfr_q : '0;
  end

endmodule

// File: tb/tb_shift_sfr_sequencer.sv
// Directed bench for shift_sfr_sequencer driving a behavioural left/right shift SFR.
// Each scenario task drives stimulus and compares against hand-computed values.
// Inputs driven at/after negedge, outputs sampled at negedge.
module tb_shift_sfr_sequencer;

  localparam int SIZE  = 32;
  localparam int AMT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_ld;
  logic             cmd_dir;
  logic [AMT_W-1:0] cmd_amt;
  logic [SIZE-1:0]  cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [SIZE-1:0]  rsp_data;
  logic             sfr_ld;
  logic             sfr_left;
  logic             sfr_right;
  logic [SIZE-1:0]  sfr_d;
  logic [SIZE-1:0]  sfr_q = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural shift register standing in for the downstream SFR; it has no reset.
  always @(posedge clk) begin
    if (sfr_ld)         sfr_q <= sfr_d;
    else if (sfr_left)  sfr_q <= sfr_q << 1;
    else if (sfr_right) sfr_q <= sfr_q >> 1;
  end

  shift_sfr_sequencer #(
    .SIZE  (SIZE),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ld    (cmd_ld),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .sfr_ld    (sfr_ld),
    .sfr_left  (sfr_left),
    .sfr_right (sfr_right),
    .sfr_d     (sfr_d),
    .sfr_q     (sfr_q)
  );

  // Issue one command from a negedge in IDLE, then watch until rsp_valid (or timeout).
  // Edge count is the number of posedges after the accepting edge. Leaves at a negedge in RESP.
  task automatic run_cmd(input logic ld, input logic dir, input logic [AMT_W-1:0] amt,
                         input logic [SIZE-1:0] data,
                         output int e, output int n_ld, output int n_lf, output int n_rt,
                         output logic [SIZE-1:0] ld_d, output logic [SIZE-1:0] rd,
                         output int viol);
    e = 0; n_ld = 0; n_lf = 0; n_rt = 0; viol = 0; ld_d = '0; rd = '0;
    if (!cmd_ready) viol++;
    cmd_ld = ld; cmd_dir = dir; cmd_amt = amt; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_dir = 1'b0; cmd_amt = '0; cmd_data = '0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (e > 100) begin
        e = 999;
        break;
      end
      if ((int'(sfr_ld) + int'(sfr_left) + int'(sfr_right)) > 1) viol++;
      if (!sfr_ld && (sfr_d != '0)) viol++;
      if (cmd_ready) viol++;
      if (sfr_ld) begin
        n_ld++;
        ld_d = sfr_d;
      end
      if (sfr_left)  n_lf++;
      if (sfr_right) n_rt++;
      @(posedge clk);
      e++;
    end
    rd = rsp_data;
  endtask

  // Complete the response handshake; leaves at a negedge back in IDLE.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_dir = 1'b0; cmd_amt = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({sfr_ld, sfr_left, sfr_right} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {sfr_ld, sfr_left, sfr_right}); end
    checks++; if (sfr_d !== '0) begin failures++; $display("FAIL reset_sfr_d got=%h exp=0", sfr_d); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_left();
    int e, nl, nlf, nrt, v;
    logic [SIZE-1:0] ldd, rd;
    run_cmd(1'b1, 1'b0, 6'd4, 32'h0000_00F0, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (e != 5) begin failures++; $display("FAIL ldl_latency got=%0d exp=5", e); end
    checks++; if ({nl, nlf, nrt} != {32'd1, 32'd4, 32'd0}) begin failures++; $display("FAIL ldl_ctl_cycles got ld=%0d l=%0d r=%0d exp 1/4/0", nl, nlf, nrt); end
    checks++; if (ldd !== 32'h0000_00F0) begin failures++; $display("FAIL ldl_sfr_d got=%h exp=000000f0", ldd); end
    checks++; if (rd !== 32'h0000_0F00) begin failures++; $display("FAIL ldl_rsp_data got=%h exp=00000f00", rd); end
    checks++; if (v != 0) begin failures++; $display("FAIL ldl_invariants got=%0d exp=0", v); end
    take_rsp();
  endtask

  task automatic test_right_noload();
    int e, nl, nlf, nrt, v;
    logic [SIZE-1:0] ldd, rd;
    run_cmd(1'b1, 1'b1, 6'd0, 32'h8000_0000, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if ((e != 1) || (rd !== 32'h8000_0000)) begin failures++; $display("FAIL rt_preload got e=%0d d=%h exp 1/80000000", e, rd); end
    take_rsp();
    run_cmd(1'b0, 1'b1, 6'd8, 32'hDEAD_BEEF, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (e != 8) begin failures++; $display("FAIL rt_latency got=%0d exp=8", e); end
    checks++; if ({nl, nlf, nrt} != {32'd0, 32'd0, 32'd8}) begin failures++; $display("FAIL rt_ctl_cycles got ld=%0d l=%0d r=%0d exp 0/0/8", nl, nlf, nrt); end
    checks++; if (rd !== 32'h0080_0000) begin failures++; $display("FAIL rt_rsp_data got=%h exp=00800000", rd); end
    checks++; if (v != 0) begin failures++; $display("FAIL rt_invariants got=%0d exp=0", v); end
    take_rsp();
  endtask

  task automatic test_clamp_read();
    int e, nl, nlf, nrt, v;
    logic [SIZE-1:0] ldd, rd;
    run_cmd(1'b1, 1'b0, 6'd40, 32'hFFFF_FFFF, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (e != 33) begin failures++; $display("FAIL clamp_latency got=%0d exp=33", e); end
    checks++; if (nlf != 32) begin failures++; $display("FAIL clamp_shift_cycles got=%0d exp=32", nlf); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL clamp_rsp_data got=%h exp=0", rd); end
    take_rsp();
    run_cmd(1'b0, 1'b0, 6'd0, 32'h1234_5678, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (e != 0) begin failures++; $display("FAIL read_latency got=%0d exp=0", e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_rsp_data got=%h exp=0", rd); end
    take_rsp();
    // Exactly SIZE is the clamp boundary itself; a single set bit must be pushed out.
    run_cmd(1'b1, 1'b1, 6'd32, 32'h8000_0001, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if ((e != 33) || (nrt != 32) || (rd !== 32'h0)) begin failures++; $display("FAIL clamp32 got e=%0d r=%0d d=%h exp 33/32/0", e, nrt, rd); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int e, nl, nlf, nrt, v;
    logic [SIZE-1:0] ldd, rd;
    int bad;
    run_cmd(1'b1, 1'b0, 6'd1, 32'h0000_0003, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (rd !== 32'h0000_0006) begin failures++; $display("FAIL bp_rsp_data got=%h exp=00000006", rd); end
    // Next command (plain read) waits on cmd_valid while the response is stalled.
    cmd_ld = 1'b0; cmd_dir = 1'b0; cmd_amt = '0; cmd_data = 32'hFFFF_0000; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((rsp_valid !== 1'b1) || (rsp_data !== 32'h0000_0006) || (cmd_ready !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d bad cycles exp=0", bad); end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL bp_bubble got rdy/vld=%b exp=10", {cmd_ready, rsp_valid}); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = '0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000_0006}) begin failures++; $display("FAIL bp_next_accept got vld=%b d=%h exp 1/00000006", rsp_valid, rsp_data); end
    take_rsp();
  endtask

  task automatic test_reset_mid_shift();
    int e, nl, nlf, nrt, v;
    logic [SIZE-1:0] ldd, rd;
    int bad;
    run_cmd(1'b1, 1'b0, 6'd0, 32'h0000_0001, e, nl, nlf, nrt, ldd, rd, v);
    take_rsp();
    cmd_ld = 1'b0; cmd_dir = 1'b0; cmd_amt = 6'd6; cmd_data = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_amt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({sfr_ld, sfr_left, sfr_right, rsp_valid} !== 4'b0000) begin failures++; $display("FAIL midrst_ctl got=%b exp=0000", {sfr_ld, sfr_left, sfr_right, rsp_valid}); end
    checks++; if (sfr_q !== 32'h0000_0004) begin failures++; $display("FAIL midrst_sfr_q got=%h exp=00000004", sfr_q); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ((rsp_valid !== 1'b0) || (cmd_ready !== 1'b1)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_idle got=%0d bad cycles exp=0", bad); end
    run_cmd(1'b0, 1'b0, 6'd0, 32'h0, e, nl, nlf, nrt, ldd, rd, v);
    checks++; if (rd !== 32'h0000_0004) begin failures++; $display("FAIL midrst_read got=%h exp=00000004", rd); end
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_load_left();
    test_right_noload();
    test_clamp_read();
    test_backpressure();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
